// File: rtl/systolic_pkg.sv
// ============================================================================
//  Module : systolic_pkg
//  Brief  : Shared types, default widths and saturating-add helper for the PE.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } pe_state_t;

  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF  = 32;
  localparam int K_MAX_DEF  = 256;
  localparam int SAT_W      = 64;

  typedef struct packed {
    logic [SAT_W-1:0] sum;
    logic             sat;
  } sat_res_t;

  // Operands arrive sign-extended to SAT_W, so the raw sum cannot wrap for acc_w <= 62.
  function automatic sat_res_t sat_add(input logic signed [SAT_W-1:0] acc,
                                       input logic signed [SAT_W-1:0] addend,
                                       input int                      acc_w);
    sat_res_t                r;
    logic signed [SAT_W-1:0] s;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    s  = acc + addend;
    r.sat = 1'b0;
    r.sum = s;
    if (s > hi) begin
      r.sum = hi;
      r.sat = 1'b1;
    end else if (s < lo) begin
      r.sum = lo;
      r.sat = 1'b1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pe_mac_pipe.sv
// ============================================================================
//  Module : pe_mac_pipe
//  Brief  : Two-stage signed multiply / saturating accumulate with clear.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module pe_mac_pipe
  import systolic_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [ACC_W-1:0]  acc_o,
  output logic              sat_o,
  output logic              empty_o
);

  logic signed [2*DATA_W-1:0] prod_q;
  logic signed [2*DATA_W-1:0] prod_d;
  logic                       v1_q;
  logic signed [ACC_W-1:0]    acc_q;
  logic                       sat_q;
  sat_res_t                   sum_d;

  assign prod_d = $signed({{DATA_W{a_i[DATA_W-1]}}, a_i}) *
                  $signed({{DATA_W{b_i[DATA_W-1]}}, b_i});
  assign sum_d  = sat_add(SAT_W'(acc_q), SAT_W'(prod_q), ACC_W);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_q <= '0;
      v1_q   <= 1'b0;
      acc_q  <= '0;
      sat_q  <= 1'b0;
    end else if (clr_i) begin
      prod_q <= '0;
      v1_q   <= 1'b0;
      acc_q  <= '0;
      sat_q  <= 1'b0;
    end else begin
      v1_q <= en_i;
      if (en_i) prod_q <= prod_d;
      if (v1_q) begin
        acc_q <= sum_d.sum[ACC_W-1:0];
        sat_q <= sat_q | sum_d.sat;
      end
    end
  end

  assign acc_o   = acc_q;
  assign sat_o   = sat_q;
  assign empty_o = ~v1_q;

endmodule

`default_nettype wire

// File: rtl/systolic_pe_os.sv
// ============================================================================
//  Module : systolic_pe_os
//  Brief  : Output-stationary systolic PE: operand forwarding, tile FSM, result port.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module systolic_pe_os
  import systolic_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int K_MAX  = K_MAX_DEF,
  parameter int CNT_W  = $clog2(K_MAX + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  k_len,
  input  logic [DATA_W-1:0] a_in,
  input  logic              a_valid_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic              b_valid_in,
  output logic [DATA_W-1:0] a_out,
  output logic              a_valid_out,
  output logic [DATA_W-1:0] b_out,
  output logic              b_valid_out,
  output logic [ACC_W-1:0]  res_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_sat,
  output logic              err_mismatch,
  output logic              busy
);

  pe_state_t        state_q, state_d;
  logic [CNT_W-1:0] klen_q, klen_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             mac_clr;
  logic             mac_fire;
  logic             mac_empty;

  always_comb begin
    state_d  = state_q;
    klen_d   = klen_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    mac_clr  = 1'b0;
    mac_fire = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACCUM;
          klen_d  = k_len;
          cnt_d   = '0;
          err_d   = 1'b0;
          mac_clr = 1'b1;
        end
      end
      ACCUM: begin
        if (a_valid_in ^ b_valid_in) err_d = 1'b1;
        if (a_valid_in && b_valid_in && (cnt_q < klen_q)) begin
          mac_fire = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
        end
        // Leave only once the last product has landed in the accumulator.
        if ((cnt_q == klen_q) && mac_empty) state_d = HOLD;
      end
      HOLD: begin
        if (res_ready) begin
          if (start) begin
            state_d = ACCUM;
            klen_d  = k_len;
            cnt_d   = '0;
            err_d   = 1'b0;
            mac_clr = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      klen_q      <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      a_out       <= '0;
      a_valid_out <= 1'b0;
      b_out       <= '0;
      b_valid_out <= 1'b0;
    end else begin
      state_q     <= state_d;
      klen_q      <= klen_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      a_out       <= a_in;
      a_valid_out <= a_valid_in;
      b_out       <= b_in;
      b_valid_out <= b_valid_in;
    end
  end

  pe_mac_pipe #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (mac_clr),
    .en_i    (mac_fire),
    .a_i     (a_in),
    .b_i     (b_in),
    .acc_o   (res_data),
    .sat_o   (res_sat),
    .empty_o (mac_empty)
  );

  assign res_valid    = (state_q == HOLD);
  assign busy         = (state_q != IDLE);
  assign err_mismatch = err_q;

endmodule

`default_nettype wire

// File: tb/tb_systolic_pe_os.sv
// ============================================================================
//  Module : tb_systolic_pe_os
//  Brief  : Directed self-checking bench for systolic_pe_os (ACC_W 32 and 16).
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_systolic_pe_os;

  localparam int CNT_W = 9;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] k_len = '0;
  logic [7:0]       a_in = '0;
  logic             a_valid_in = 1'b0;
  logic [7:0]       b_in = '0;
  logic             b_valid_in = 1'b0;
  logic             res_ready = 1'b0;

  logic [7:0]  a_out, b_out, a_out16, b_out16;
  logic        a_valid_out, b_valid_out, a_valid_out16, b_valid_out16;
  logic [31:0] res_data;
  logic [15:0] res_data16;
  logic        res_valid, res_sat, err_mismatch, busy;
  logic        res_valid16, res_sat16, err_mismatch16, busy16;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  systolic_pe_os #(.DATA_W(8), .ACC_W(32), .K_MAX(256)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len),
    .a_in(a_in), .a_valid_in(a_valid_in), .b_in(b_in), .b_valid_in(b_valid_in),
    .a_out(a_out), .a_valid_out(a_valid_out), .b_out(b_out), .b_valid_out(b_valid_out),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready), .res_sat(res_sat),
    .err_mismatch(err_mismatch), .busy(busy)
  );

  systolic_pe_os #(.DATA_W(8), .ACC_W(16), .K_MAX(256)) dut16 (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len),
    .a_in(a_in), .a_valid_in(a_valid_in), .b_in(b_in), .b_valid_in(b_valid_in),
    .a_out(a_out16), .a_valid_out(a_valid_out16), .b_out(b_out16), .b_valid_out(b_valid_out16),
    .res_data(res_data16), .res_valid(res_valid16), .res_ready(res_ready), .res_sat(res_sat16),
    .err_mismatch(err_mismatch16), .busy(busy16)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_tile(input int k);
    start = 1'b1;
    k_len = CNT_W'(k);
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input logic [7:0] a, input logic [7:0] b);
    a_in = a; b_in = b;
    a_valid_in = 1'b1; b_valid_in = 1'b1;
    tick();
    a_valid_in = 1'b0; b_valid_in = 1'b0;
  endtask

  task automatic wait_hold(output int lat);
    lat = 0;
    while (!res_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("hold_timeout", {31'd0, res_valid}, 32'd1);
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("drop_valid", {31'd0, res_valid}, 32'd0);
  endtask

  initial begin : main
    logic [7:0] avec [4];
    int lat;
    avec = '{8'd2, 8'd4, 8'd8, 8'd16};

    tick(); tick();
    rst = 1'b0;
    chk("rst_res_data",  res_data, 32'd0);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_busy",      {31'd0, busy}, 32'd0);
    chk("rst_a_out",     {24'd0, a_out}, 32'd0);

    // 1: basic dot product, forwarding, latency
    begin_tile(4);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      feed(avec[i], 8'd8);
      chk("t1_a_out", {23'd0, a_valid_out, a_out}, {23'd0, 1'b1, avec[i]});
      chk("t1_b_out", {23'd0, b_valid_out, b_out}, {23'd0, 1'b1, 8'd8});
    end
    chk("t1_valid_t0", {31'd0, res_valid}, 32'd0);
    tick();
    chk("t1_valid_t1", {31'd0, res_valid}, 32'd0);
    tick();
    chk("t1_valid_t2", {31'd0, res_valid}, 32'd1);
    chk("t1_data", res_data, 32'd240);
    chk("t1_sat",  {31'd0, res_sat}, 32'd0);
    handshake();
    chk("t1_idle", {31'd0, busy}, 32'd0);

    // 2: extreme negatives with bubbles
    begin_tile(2);
    feed(8'h80, 8'h80);
    tick(); tick(); tick();
    feed(8'h80, 8'h7F);
    wait_hold(lat);
    chk("t2_latency", lat, 32'd2);
    chk("t2_data", res_data, 32'd128);

    // 3: backpressure then back-to-back start
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_hold_valid", {31'd0, res_valid}, 32'd1);
      chk("t3_hold_data",  res_data, 32'd128);
    end
    res_ready = 1'b1; start = 1'b1; k_len = CNT_W'(1);
    a_in = 8'd3; b_in = 8'd5; a_valid_in = 1'b1; b_valid_in = 1'b1;
    tick();
    res_ready = 1'b0; start = 1'b0; a_valid_in = 1'b0; b_valid_in = 1'b0;
    chk("t3_no_idle", {30'd0, busy, res_valid}, 32'd2);
    feed(8'd3, 8'd5);
    wait_hold(lat);
    chk("t3_data", res_data, 32'd15);
    handshake();

    // 4: one-sided valid sets sticky error without consuming a slot
    begin_tile(2);
    a_in = 8'd9; a_valid_in = 1'b1; b_valid_in = 1'b0;
    tick();
    a_valid_in = 1'b0;
    chk("t4_err", {31'd0, err_mismatch}, 32'd1);
    feed(8'd2, 8'd3);
    feed(8'd4, 8'd5);
    wait_hold(lat);
    chk("t4_data", res_data, 32'd26);
    chk("t4_err_sticky", {31'd0, err_mismatch}, 32'd1);
    handshake();

    // 5: k_len = 0, then saturation on the narrow instance
    begin_tile(0);
    chk("t5_err_cleared", {31'd0, err_mismatch}, 32'd0);
    tick();
    chk("t5_k0_valid", {30'd0, res_valid16, res_valid}, 32'd3);
    chk("t5_k0_data",  res_data, 32'd0);
    handshake();
    begin_tile(3);
    feed(8'd127, 8'd127);
    feed(8'd127, 8'd127);
    feed(8'd127, 8'd127);
    feed(8'd127, 8'd127);
    wait_hold(lat);
    chk("t5_data16", {16'd0, res_data16}, 32'd32767);
    chk("t5_sat16",  {31'd0, res_sat16}, 32'd1);
    chk("t5_data32", res_data, 32'd48387);
    chk("t5_sat32",  {31'd0, res_sat}, 32'd0);
    handshake();

    // 6: asynchronous reset mid-tile
    begin_tile(4);
    feed(8'd1, 8'd1);
    a_in = 8'd1; b_in = 8'd1; a_valid_in = 1'b1; b_valid_in = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_outs", {busy, res_valid, err_mismatch, a_valid_out, b_valid_out, a_out, b_out},
        32'd0);
    chk("t6_rst_data", res_data, 32'd0);
    a_valid_in = 1'b0; b_valid_in = 1'b0;
    tick();
    rst = 1'b0;
    begin_tile(2);
    feed(8'd6, 8'd7);
    feed(8'hFD, 8'd4);
    wait_hold(lat);
    chk("t6_data", res_data, 32'd30);
    handshake();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
